// File: rtl/video_pkg.sv
// Shared types and defaults for the video timing receiver.
// Holds lock/irq state encodings and a saturating error-count helper.
package video_pkg;

   localparam int unsigned DEF_LINE_LEN    = 512;
   localparam int unsigned DEF_FRAME_LINES = 262;
   localparam int unsigned DEF_ACK_PULSE   = 4;

   typedef enum logic [1:0] {
      LK_SEARCH,
      LK_ALIGN,
      LK_LOCKED,
      LK_LOST
   } lock_st_t;

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_PEND,
      IRQ_ACK,
      IRQ_WAIT_HI
   } irq_st_t;

   function automatic logic [7:0] sat_add8(
      input logic [7:0] a,
      input logic [1:0] b
   );
      logic [8:0] s;
      s = {1'b0, a} + {7'd0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Both stages clear to zero on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/video_timing_rx.sv
// Recovers pixel timing from an asynchronous video source, tracks lock
// against the expected geometry and handles the VBK interrupt handshake.
module video_timing_rx
   import video_pkg::*;
#(
   parameter int unsigned EXP_LINE_LEN    = DEF_LINE_LEN,
   parameter int unsigned EXP_FRAME_LINES = DEF_FRAME_LINES,
   parameter int unsigned ACK_PULSE       = DEF_ACK_PULSE
)(
   input  logic       clk100,
   input  logic       rst_b,
   input  logic       MCKR,
   input  logic       HSYNC,
   input  logic       HBLANK_b,
   input  logic       VSYNC,
   input  logic       VBLANK_b,
   input  logic       VBKINT_b,
   input  logic       irq_ack,
   output logic       pix_ce,
   output logic [8:0] hpos,
   output logic [8:0] vpos,
   output logic       active,
   output logic       frame_start,
   output logic       locked,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines,
   output logic [7:0] err_cnt,
   output logic       vbk_irq,
   output logic       VBKACK_b
);

   localparam logic [9:0] C_LLEN = 10'(EXP_LINE_LEN);
   localparam logic [9:0] C_FLIN = 10'(EXP_FRAME_LINES);
   localparam logic [7:0] C_ALST = 8'(ACK_PULSE - 1);

   logic w_mck, w_hs, w_vs, w_hb, w_vb, w_vbk;

   sync_2ff u_sync_mck (.clk(clk100), .rst_n(rst_b), .i_d(MCKR),     .o_q(w_mck));
   sync_2ff u_sync_hs  (.clk(clk100), .rst_n(rst_b), .i_d(HSYNC),    .o_q(w_hs));
   sync_2ff u_sync_vs  (.clk(clk100), .rst_n(rst_b), .i_d(VSYNC),    .o_q(w_vs));
   sync_2ff u_sync_hb  (.clk(clk100), .rst_n(rst_b), .i_d(HBLANK_b), .o_q(w_hb));
   sync_2ff u_sync_vb  (.clk(clk100), .rst_n(rst_b), .i_d(VBLANK_b), .o_q(w_vb));
   sync_2ff u_sync_vbk (.clk(clk100), .rst_n(rst_b), .i_d(VBKINT_b), .o_q(w_vbk));

   logic [1:0] r_warm;
   logic       r_mck_q, r_hs_q, r_vs_q, r_vbk_q;
   logic       w_rdy, w_ce, w_hs_rise, w_vs_rise, w_vbk_fall;

   // Edge history tracks the synchronizers until they hold post-reset data.
   assign w_rdy      = (r_warm == 2'd3);
   assign w_ce       = w_rdy & w_mck & ~r_mck_q;
   assign w_hs_rise  = w_ce & w_hs & ~r_hs_q;
   assign w_vs_rise  = w_ce & w_vs & ~r_vs_q;
   assign w_vbk_fall = w_ce & ~w_vbk & r_vbk_q;

   always_ff @(posedge clk100 or negedge rst_b) begin
      if (!rst_b) begin
         r_warm  <= 2'd0;
         r_mck_q <= 1'b0;
         r_hs_q  <= 1'b0;
         r_vs_q  <= 1'b0;
         r_vbk_q <= 1'b0;
      end else begin
         if (!w_rdy) r_warm <= r_warm + 2'd1;
         r_mck_q <= w_mck;
         if (!w_rdy || w_ce) begin
            r_hs_q  <= w_hs;
            r_vs_q  <= w_vs;
            r_vbk_q <= w_vbk;
         end
      end
   end

   logic [8:0] r_hpos, r_vpos;
   logic [9:0] r_line_len, r_frame_lines;
   logic       r_active, r_fstart;
   logic [9:0] w_hlen, w_vlen;

   assign w_hlen = {1'b0, r_hpos} + 10'd1;
   assign w_vlen = {1'b0, r_vpos} + 10'd1;

   always_ff @(posedge clk100 or negedge rst_b) begin
      if (!rst_b) begin
         r_hpos        <= 9'd0;
         r_vpos        <= 9'd0;
         r_line_len    <= 10'd0;
         r_frame_lines <= 10'd0;
         r_active      <= 1'b0;
         r_fstart      <= 1'b0;
      end else begin
         r_fstart <= w_vs_rise;
         if (w_ce) begin
            r_active <= w_hb & w_vb;
            if (w_hs_rise) begin
               r_hpos     <= 9'd0;
               r_line_len <= w_hlen;
            end else if (r_hpos != 9'h1FF) begin
               r_hpos <= r_hpos + 9'd1;
            end
            if (w_vs_rise) begin
               r_vpos        <= 9'd0;
               r_frame_lines <= w_vlen;
            end else if (w_hs_rise && r_vpos != 9'h1FF) begin
               r_vpos <= r_vpos + 9'd1;
            end
         end
      end
   end

   lock_st_t   r_lk;
   logic       r_good, r_bad, r_fbad;
   logic [7:0] r_err;
   logic       w_lbad, w_flbad, w_fbad;
   logic [1:0] w_inc;

   assign w_lbad  = w_hs_rise & (w_hlen != C_LLEN);
   assign w_flbad = w_vs_rise & (w_vlen != C_FLIN);
   assign w_fbad  = r_fbad | w_lbad | w_flbad;
   assign w_inc   = {1'b0, w_lbad} + {1'b0, w_flbad};

   always_ff @(posedge clk100 or negedge rst_b) begin
      if (!rst_b) begin
         r_lk   <= LK_SEARCH;
         r_good <= 1'b0;
         r_bad  <= 1'b0;
         r_fbad <= 1'b0;
         r_err  <= 8'd0;
      end else begin
         if (w_vs_rise)   r_fbad <= 1'b0;
         else if (w_lbad) r_fbad <= 1'b1;
         if (r_lk == LK_LOCKED) r_err <= sat_add8(r_err, w_inc);
         unique case (r_lk)
            LK_SEARCH: begin
               if (w_vs_rise) begin
                  r_lk   <= LK_ALIGN;
                  r_good <= 1'b0;
               end
            end
            LK_ALIGN: begin
               if (w_vs_rise) begin
                  if (w_fbad) begin
                     r_good <= 1'b0;
                  end else if (r_good) begin
                     r_lk   <= LK_LOCKED;
                     r_good <= 1'b0;
                     r_bad  <= 1'b0;
                  end else begin
                     r_good <= 1'b1;
                  end
               end
            end
            LK_LOCKED: begin
               if (w_vs_rise) begin
                  if (!w_fbad)    r_bad <= 1'b0;
                  else if (r_bad) r_lk  <= LK_LOST;
                  else            r_bad <= 1'b1;
               end
            end
            LK_LOST: begin
               r_lk  <= LK_SEARCH;
               r_bad <= 1'b0;
            end
            default: r_lk <= LK_SEARCH;
         endcase
      end
   end

   irq_st_t    r_irq;
   logic       r_vbk_irq, r_ackb;
   logic [7:0] r_acnt;

   always_ff @(posedge clk100 or negedge rst_b) begin
      if (!rst_b) begin
         r_irq     <= IRQ_IDLE;
         r_vbk_irq <= 1'b0;
         r_ackb    <= 1'b1;
         r_acnt    <= 8'd0;
      end else begin
         unique case (r_irq)
            IRQ_IDLE: begin
               if (w_vbk_fall) begin
                  r_irq     <= IRQ_PEND;
                  r_vbk_irq <= 1'b1;
               end
            end
            IRQ_PEND: begin
               if (irq_ack) begin
                  r_irq     <= IRQ_ACK;
                  r_vbk_irq <= 1'b0;
                  r_ackb    <= 1'b0;
                  r_acnt    <= 8'd0;
               end
            end
            IRQ_ACK: begin
               if (w_ce) begin
                  if (r_acnt == C_ALST) begin
                     r_irq  <= IRQ_WAIT_HI;
                     r_ackb <= 1'b1;
                  end else begin
                     r_acnt <= r_acnt + 8'd1;
                  end
               end
            end
            IRQ_WAIT_HI: begin
               if (w_ce && w_vbk) r_irq <= IRQ_IDLE;
            end
            default: r_irq <= IRQ_IDLE;
         endcase
      end
   end

   assign pix_ce      = w_ce;
   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign active      = r_active;
   assign frame_start = r_fstart;
   assign locked      = (r_lk == LK_LOCKED);
   assign line_len    = r_line_len;
   assign frame_lines = r_frame_lines;
   assign err_cnt     = r_err;
   assign vbk_irq     = r_vbk_irq;
   assign VBKACK_b    = r_ackb;

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx using a reduced 32x6 frame geometry.
// A free-running generator produces MCKR/HSYNC/VSYNC/blanking.
module tb_video_timing_rx;

   localparam int LL = 32;
   localparam int FL = 6;

   logic       clk100 = 1'b0;
   logic       rst_b;
   logic       MCKR, HSYNC, HBLANK_b, VSYNC, VBLANK_b, VBKINT_b;
   logic       irq_ack;
   logic       pix_ce, active, frame_start, locked, vbk_irq, VBKACK_b;
   logic [8:0] hpos, vpos;
   logic [9:0] line_len, frame_lines;
   logic [7:0] err_cnt;

   int errs   = 0;
   int checks = 0;

   int gen_en = 0;
   int mck_half = 7;
   int hsync_off = 0;
   int bad_req = 0;
   int bad_done = 0;
   int gen_frame_cnt = 0;
   int g_line = 0;
   int g_llen = LL;
   bit g_fbad;

   video_timing_rx #(
      .EXP_LINE_LEN(32),
      .EXP_FRAME_LINES(6),
      .ACK_PULSE(4)
   ) dut (
      .clk100(clk100), .rst_b(rst_b),
      .MCKR(MCKR), .HSYNC(HSYNC), .HBLANK_b(HBLANK_b),
      .VSYNC(VSYNC), .VBLANK_b(VBLANK_b), .VBKINT_b(VBKINT_b),
      .irq_ack(irq_ack), .pix_ce(pix_ce), .hpos(hpos), .vpos(vpos),
      .active(active), .frame_start(frame_start), .locked(locked),
      .line_len(line_len), .frame_lines(frame_lines),
      .err_cnt(err_cnt), .vbk_irq(vbk_irq), .VBKACK_b(VBKACK_b)
   );

   always #5 clk100 = ~clk100;

   // Video source: line 2 of a requested frame is one pixel short.
   initial begin
      MCKR = 0; HSYNC = 0; VSYNC = 0; HBLANK_b = 0; VBLANK_b = 0;
      wait (gen_en != 0);
      forever begin
         g_fbad = (bad_done < bad_req);
         if (g_fbad) bad_done++;
         gen_frame_cnt++;
         for (int l = 0; l < FL; l++) begin
            g_line = l;
            g_llen = (g_fbad && l == 2) ? LL - 1 : LL;
            for (int p = 0; p < g_llen; p++) begin
               HSYNC    = (p == 0) && (hsync_off == 0);
               VSYNC    = (p == 0) && (l == 0) && (hsync_off == 0);
               HBLANK_b = (p < LL - 8);
               VBLANK_b = (l < FL - 2);
               MCKR = 0;
               repeat (mck_half) @(negedge clk100);
               MCKR = 1;
               repeat (mck_half) @(negedge clk100);
            end
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk100);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk100);
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      @(negedge clk100);
      irq_ack = 1'b0;
   endtask

   task automatic wait_frames(input int target, input string nm);
      int n = 0;
      while (gen_frame_cnt < target && n < 20000) begin
         @(negedge clk100);
         n++;
      end
      checks++;
      if (gen_frame_cnt < target) begin
         errs++;
         $display("FAIL %s: frame count %0d want %0d", nm, gen_frame_cnt, target);
      end
      wait_cyc(4 * mck_half + 10);
   endtask

   task automatic test_reset();
      rst_b = 1'b0; irq_ack = 1'b0; VBKINT_b = 1'b1;
      wait_cyc(3);
      checks++;
      if ({hpos, vpos} !== 18'd0) begin
         errs++; $display("FAIL rst_pos: got %h want 0", {hpos, vpos});
      end
      checks++;
      if ({line_len, frame_lines, err_cnt} !== 28'd0) begin
         errs++; $display("FAIL rst_len: got %h want 0", {line_len, frame_lines, err_cnt});
      end
      checks++;
      if ({pix_ce, active, frame_start, locked, vbk_irq, VBKACK_b} !== 6'b000001) begin
         errs++; $display("FAIL rst_flags: got %b want 000001",
                          {pix_ce, active, frame_start, locked, vbk_irq, VBKACK_b});
      end
      rst_b = 1'b1;
      wait_cyc(5);
      checks++;
      if (locked !== 1'b0) begin
         errs++; $display("FAIL rst_search: locked %b want 0", locked);
      end
   endtask

   task automatic test_nominal();
      int n;
      mck_half = 7;
      gen_en = 1;
      wait_frames(2, "nom_f2");
      checks++;
      if (locked !== 1'b0) begin
         errs++; $display("FAIL align_one: locked %b want 0", locked);
      end
      checks++;
      if (frame_lines !== 10'd6) begin
         errs++; $display("FAIL nom_flines1: got %0d want 6", frame_lines);
      end
      n = 0;
      while (frame_start !== 1'b1 && n < 5000) begin
         @(negedge clk100);
         n++;
      end
      checks++;
      if (frame_start !== 1'b1 || vpos !== 9'd0 || hpos !== 9'd0) begin
         errs++; $display("FAIL fstart: fs %b vpos %0d hpos %0d want 1 0 0",
                          frame_start, vpos, hpos);
      end
      checks++;
      if (active !== 1'b1) begin
         errs++; $display("FAIL active_on: got %b want 1", active);
      end
      n = 0;
      while (g_line != 5 && n < 5000) begin
         @(negedge clk100);
         n++;
      end
      wait_cyc(4 * mck_half + 10);
      checks++;
      if (vpos !== 9'd5) begin
         errs++; $display("FAIL vpos5: got %0d want 5", vpos);
      end
      checks++;
      if (active !== 1'b0) begin
         errs++; $display("FAIL active_off: got %b want 0", active);
      end
      checks++;
      if (locked !== 1'b1 || line_len !== 10'd32 || frame_lines !== 10'd6) begin
         errs++; $display("FAIL nom_lock: locked %b llen %0d flines %0d want 1 32 6",
                          locked, line_len, frame_lines);
      end
      checks++;
      if (err_cnt !== 8'd0) begin
         errs++; $display("FAIL nom_err: got %0d want 0", err_cnt);
      end
   endtask

   task automatic test_bad_line();
      int base;
      mck_half = 3;
      base = gen_frame_cnt;
      bad_req = 1;
      wait_frames(base + 2, "bad1_f");
      checks++;
      if (err_cnt !== 8'd1 || locked !== 1'b1) begin
         errs++; $display("FAIL bad_single: err %0d locked %b want 1 1", err_cnt, locked);
      end
      checks++;
      if (line_len !== 10'd32) begin
         errs++; $display("FAIL bad_llen: got %0d want 32", line_len);
      end
      bad_req = 3;
      wait_frames(base + 4, "bad2_f");
      checks++;
      if (err_cnt !== 8'd2 || locked !== 1'b1) begin
         errs++; $display("FAIL bad_first: err %0d locked %b want 2 1", err_cnt, locked);
      end
      wait_frames(base + 5, "bad3_f");
      checks++;
      if (err_cnt !== 8'd3 || locked !== 1'b0) begin
         errs++; $display("FAIL bad_lost: err %0d locked %b want 3 0", err_cnt, locked);
      end
      wait_frames(base + 8, "relock_f");
      checks++;
      if (err_cnt !== 8'd3 || locked !== 1'b1) begin
         errs++; $display("FAIL relock: err %0d locked %b want 3 1", err_cnt, locked);
      end
   endtask

   task automatic test_irq_ack();
      int n;
      int ce_lo;
      VBKINT_b = 1'b0;
      n = 0;
      while (vbk_irq !== 1'b1 && n < 200) begin
         @(negedge clk100);
         n++;
      end
      checks++;
      if (vbk_irq !== 1'b1) begin
         errs++; $display("FAIL irq_set: got %b want 1", vbk_irq);
      end
      wait_cyc(10);
      irq_ack = 1'b1;
      @(negedge clk100);
      irq_ack = 1'b0;
      checks++;
      if (vbk_irq !== 1'b0 || VBKACK_b !== 1'b0) begin
         errs++; $display("FAIL ack_start: irq %b ackb %b want 0 0", vbk_irq, VBKACK_b);
      end
      n = 0;
      ce_lo = 0;
      while (VBKACK_b === 1'b0 && n < 500) begin
         if (pix_ce) ce_lo++;
         @(negedge clk100);
         n++;
      end
      checks++;
      if (ce_lo != 4 || VBKACK_b !== 1'b1) begin
         errs++; $display("FAIL ack_width: ce %0d ackb %b want 4 1", ce_lo, VBKACK_b);
      end
   endtask

   task automatic test_ack_ignored();
      int n;
      bit   bad;
      pulse_ack();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (VBKACK_b !== 1'b1 || vbk_irq !== 1'b0) bad = 1;
         @(negedge clk100);
      end
      checks++;
      if (bad) begin
         errs++; $display("FAIL ack_waithi: ackb %b irq %b want 1 0", VBKACK_b, vbk_irq);
      end
      VBKINT_b = 1'b1;
      wait_cyc(40);
      pulse_ack();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (VBKACK_b !== 1'b1 || vbk_irq !== 1'b0) bad = 1;
         @(negedge clk100);
      end
      checks++;
      if (bad) begin
         errs++; $display("FAIL ack_idle: ackb %b irq %b want 1 0", VBKACK_b, vbk_irq);
      end
      mck_half = 7;
      wait_cyc(30);
      VBKINT_b = 1'b0;
      n = 0;
      while (vbk_irq !== 1'b1 && n < 300) begin
         @(negedge clk100);
         n++;
      end
      checks++;
      if (vbk_irq !== 1'b1) begin
         errs++; $display("FAIL irq_set2: got %b want 1", vbk_irq);
      end
      wait_cyc(10);
      pulse_ack();
      wait_cyc(2);
      VBKINT_b = 1'b1;
      wait_cyc(16);
      VBKINT_b = 1'b0;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         if (vbk_irq !== 1'b0) bad = 1;
         @(negedge clk100);
      end
      checks++;
      if (bad || VBKACK_b !== 1'b1) begin
         errs++; $display("FAIL refall: irq seen %b ackb %b want 0 1", bad, VBKACK_b);
      end
      VBKINT_b = 1'b1;
      wait_cyc(40);
      VBKINT_b = 1'b0;
      n = 0;
      while (vbk_irq !== 1'b1 && n < 300) begin
         @(negedge clk100);
         n++;
      end
      checks++;
      if (vbk_irq !== 1'b1) begin
         errs++; $display("FAIL irq_rearm: got %b want 1", vbk_irq);
      end
   endtask

   task automatic test_hsync_sat();
      logic [8:0] v0;
      mck_half = 3;
      hsync_off = 1;
      wait_cyc(30);
      v0 = vpos;
      wait_cyc(6000);
      checks++;
      if (hpos !== 9'd511) begin
         errs++; $display("FAIL hsat: hpos %0d want 511", hpos);
      end
      checks++;
      if (vpos !== v0) begin
         errs++; $display("FAIL vhold: vpos %0d want %0d", vpos, v0);
      end
      hsync_off = 0;
   endtask

   task automatic test_reset_mid_ack();
      pulse_ack();
      checks++;
      if (VBKACK_b !== 1'b0) begin
         errs++; $display("FAIL pre_rst_ack: ackb %b want 0", VBKACK_b);
      end
      #2;
      rst_b = 1'b0;
      #1;
      checks++;
      if (VBKACK_b !== 1'b1 || vbk_irq !== 1'b0 || locked !== 1'b0) begin
         errs++; $display("FAIL rst_async: ackb %b irq %b locked %b want 1 0 0",
                          VBKACK_b, vbk_irq, locked);
      end
      checks++;
      if ({hpos, vpos, line_len, frame_lines, err_cnt} !== 46'd0) begin
         errs++; $display("FAIL rst_async_cnt: got %h want 0",
                          {hpos, vpos, line_len, frame_lines, err_cnt});
      end
      wait_cyc(3);
      rst_b = 1'b1;
      wait_frames(gen_frame_cnt + 3, "rst_relock_f");
      checks++;
      if (locked !== 1'b1 || err_cnt !== 8'd0) begin
         errs++; $display("FAIL rst_relock: locked %b err %0d want 1 0", locked, err_cnt);
      end
      checks++;
      if (line_len !== 10'd32 || frame_lines !== 10'd6) begin
         errs++; $display("FAIL rst_geom: llen %0d flines %0d want 32 6",
                          line_len, frame_lines);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_line();
      test_irq_ack();
      test_ack_ignored();
      test_hsync_sat();
      test_reset_mid_ack();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
